// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer: opcode classes, function codes
// and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_CNOP  = 4'b1000;
    localparam logic [3:0] OP_EQ    = 4'b1001;
    localparam logic [3:0] OP_GT    = 4'b1010;
    localparam logic [3:0] OP_LT    = 4'b1011;
    localparam logic [3:0] OP_SHR_A = 4'b1100;
    localparam logic [3:0] OP_SHL_A = 4'b1101;
    localparam logic [3:0] OP_SHR_B = 4'b1110;
    localparam logic [3:0] OP_SHL_B = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_rsp_select.sv
// Picks the ALU result bus for the latched opcode class, zero-extends it, and
// flags any disagreement between the class and the one-hot ALU class flags.
module alu_rsp_select
    import alu_pkg::*;
#(
    parameter int OP_DATA_WIDTH = 16
) (
    input  logic [1:0]                 i_class,
    input  logic [2*OP_DATA_WIDTH-1:0] i_arith,
    input  logic                       i_carry,
    input  logic                       i_arith_flag,
    input  logic [OP_DATA_WIDTH-1:0]   i_logic,
    input  logic                       i_logic_flag,
    input  logic [2:0]                 i_cmp,
    input  logic                       i_cmp_flag,
    input  logic [OP_DATA_WIDTH-1:0]   i_shift,
    input  logic                       i_shift_flag,
    output logic [2*OP_DATA_WIDTH-1:0] o_data,
    output logic                       o_carry,
    output logic                       o_flag_err
);

    logic [3:0] w_exp_flags;
    logic [3:0] w_flags;

    assign w_flags = {i_shift_flag, i_cmp_flag, i_logic_flag, i_arith_flag};

    always_comb begin
        o_data      = '0;
        o_carry     = 1'b0;
        w_exp_flags = 4'b0000;
        case (i_class)
            CLS_ARITH: begin
                o_data      = i_arith;
                o_carry     = i_carry;
                w_exp_flags = 4'b0001;
            end
            CLS_LOGIC: begin
                o_data      = {{OP_DATA_WIDTH{1'b0}}, i_logic};
                w_exp_flags = 4'b0010;
            end
            CLS_CMP: begin
                o_data      = {{(2*OP_DATA_WIDTH-3){1'b0}}, i_cmp};
                w_exp_flags = 4'b0100;
            end
            default: begin
                o_data      = {{OP_DATA_WIDTH{1'b0}}, i_shift};
                w_exp_flags = 4'b1000;
            end
        endcase
    end

    // Missing own flag and any stray flag both show up as an inequality.
    assign o_flag_err = (w_flags != w_exp_flags);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one ALU operation per command handshake, waits out the ALU pipeline,
// and returns a single tagged result on the response handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int OP_DATA_WIDTH = 16,
    parameter int ALU_LAT       = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [3:0]                 CMD_FUN,
    input  logic [OP_DATA_WIDTH-1:0]   CMD_A,
    input  logic [OP_DATA_WIDTH-1:0]   CMD_B,
    output logic [OP_DATA_WIDTH-1:0]   ALU_A,
    output logic [OP_DATA_WIDTH-1:0]   ALU_B,
    output logic [3:0]                 ALU_FUN,
    input  logic [2*OP_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                       Carry_OUT,
    input  logic                       Arith_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Logic_OUT,
    input  logic                       Logic_Flag,
    input  logic [2:0]                 CMP_OUT,
    input  logic                       CMP_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Shift_OUT,
    input  logic                       Shift_Flag,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [2*OP_DATA_WIDTH-1:0] RSP_DATA,
    output logic                       RSP_CARRY,
    output logic [1:0]                 RSP_CLASS,
    output logic                       RSP_ERR,
    output logic [CNT_WIDTH-1:0]       OP_CNT,
    output seq_state_t                 DBG_STATE
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends combinationally on ready.
    localparam logic [2:0] LAT_CNT = 3'(ALU_LAT);

    seq_state_t                 r_state;
    seq_state_t                 w_next_state;
    logic [2:0]                 r_wait_cnt;
    logic [OP_DATA_WIDTH-1:0]   r_alu_a;
    logic [OP_DATA_WIDTH-1:0]   r_alu_b;
    logic [3:0]                 r_alu_fun;
    logic [1:0]                 r_class;
    logic                       r_div0;
    logic [2*OP_DATA_WIDTH-1:0] r_rsp_data;
    logic                       r_rsp_carry;
    logic                       r_rsp_err;
    logic [CNT_WIDTH-1:0]       r_op_cnt;

    logic                       w_accept;
    logic                       w_capture;
    logic                       w_rsp_done;
    logic [2*OP_DATA_WIDTH-1:0] w_sel_data;
    logic                       w_sel_carry;
    logic                       w_flag_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // The count runs ALU_LAT..0 so capture lands ALU_LAT+1 edges after acceptance,
    // one edge after the registered ALU output has settled.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = CMD_VALID;
                if (CMD_VALID) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_capture = (r_wait_cnt == 3'd0);
                if (r_wait_cnt == 3'd0) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_done = RSP_READY;
                if (RSP_READY) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wait_cnt  <= 3'd0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= 4'd0;
            r_class     <= 2'd0;
            r_div0      <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= CMD_A;
                r_alu_b    <= CMD_B;
                r_alu_fun  <= CMD_FUN;
                r_class    <= CMD_FUN[3:2];
                r_div0     <= (CMD_FUN == OP_DIV) && (CMD_B == '0);
                r_wait_cnt <= LAT_CNT;
            end else if (r_state == ST_WAIT && r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (w_capture) begin
                r_rsp_data  <= r_div0 ? '0 : w_sel_data;
                r_rsp_carry <= w_sel_carry;
                r_rsp_err   <= w_flag_err | r_div0;
            end
            if (w_rsp_done) r_op_cnt <= r_op_cnt + 1'b1;
        end
    end

    alu_rsp_select #(
        .OP_DATA_WIDTH(OP_DATA_WIDTH)
    ) u_rsp_select (
        .i_class     (r_class),
        .i_arith     (Arith_OUT),
        .i_carry     (Carry_OUT),
        .i_arith_flag(Arith_Flag),
        .i_logic     (Logic_OUT),
        .i_logic_flag(Logic_Flag),
        .i_cmp       (CMP_OUT),
        .i_cmp_flag  (CMP_Flag),
        .i_shift     (Shift_OUT),
        .i_shift_flag(Shift_Flag),
        .o_data      (w_sel_data),
        .o_carry     (w_sel_carry),
        .o_flag_err  (w_flag_err)
    );

    assign CMD_READY = (r_state == ST_IDLE);
    assign RSP_VALID = (r_state == ST_RESP);
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_CARRY = r_rsp_carry;
    assign RSP_CLASS = r_class;
    assign RSP_ERR   = r_rsp_err;
    assign OP_CNT    = r_op_cnt;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a one-stage registered ALU stub;
// a second instance with a 2-bit counter shares all inputs to observe wrap.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           CMD_VALID = 1'b0;
    logic           CMD_READY;
    logic [3:0]     CMD_FUN = 4'd0;
    logic [W-1:0]   CMD_A = '0;
    logic [W-1:0]   CMD_B = '0;
    logic [W-1:0]   ALU_A, ALU_B;
    logic [3:0]     ALU_FUN;
    logic [2*W-1:0] Arith_OUT = '0;
    logic           Carry_OUT = 1'b0;
    logic           Arith_Flag = 1'b0;
    logic [W-1:0]   Logic_OUT = '0;
    logic           Logic_Flag = 1'b0;
    logic [2:0]     CMP_OUT = 3'd0;
    logic           CMP_Flag = 1'b0;
    logic [W-1:0]   Shift_OUT = '0;
    logic           Shift_Flag = 1'b0;
    logic           RSP_VALID;
    logic           RSP_READY = 1'b0;
    logic [2*W-1:0] RSP_DATA;
    logic           RSP_CARRY;
    logic [1:0]     RSP_CLASS;
    logic           RSP_ERR;
    logic [15:0]    OP_CNT;
    seq_state_t     DBG_STATE;

    logic           c2_cmd_ready, c2_rsp_valid, c2_rsp_carry, c2_rsp_err;
    logic [W-1:0]   c2_alu_a, c2_alu_b;
    logic [3:0]     c2_alu_fun;
    logic [2*W-1:0] c2_rsp_data;
    logic [1:0]     c2_rsp_class;
    logic [1:0]     c2_op_cnt;
    seq_state_t     c2_state;

    logic           force_lflag = 1'b0;
    int             n_cmp = 0;
    int             n_err = 0;
    logic [2*W-1:0] held_data;

    always #5 CLK = ~CLK;

    alu_cmd_sequencer #(.OP_DATA_WIDTH(W), .ALU_LAT(1), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_FUN(CMD_FUN), .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_CARRY(RSP_CARRY), .RSP_CLASS(RSP_CLASS), .RSP_ERR(RSP_ERR),
        .OP_CNT(OP_CNT), .DBG_STATE(DBG_STATE)
    );

    alu_cmd_sequencer #(.OP_DATA_WIDTH(W), .ALU_LAT(1), .CNT_WIDTH(2)) dut_c2 (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(c2_cmd_ready),
        .CMD_FUN(CMD_FUN), .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_A(c2_alu_a), .ALU_B(c2_alu_b), .ALU_FUN(c2_alu_fun),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .RSP_VALID(c2_rsp_valid), .RSP_READY(RSP_READY), .RSP_DATA(c2_rsp_data),
        .RSP_CARRY(c2_rsp_carry), .RSP_CLASS(c2_rsp_class), .RSP_ERR(c2_rsp_err),
        .OP_CNT(c2_op_cnt), .DBG_STATE(c2_state)
    );

    // One-stage registered ALU stub; class flags are one-hot unless forced.
    always @(posedge CLK) begin
        logic [2*W-1:0] sum;
        sum = {{W{1'b0}}, ALU_A} + {{W{1'b0}}, ALU_B};
        Arith_OUT  <= '0;
        Carry_OUT  <= 1'b0;
        Logic_OUT  <= '0;
        CMP_OUT    <= 3'd0;
        Shift_OUT  <= '0;
        Arith_Flag <= (ALU_FUN[3:2] == CLS_ARITH);
        Logic_Flag <= (ALU_FUN[3:2] == CLS_LOGIC) | force_lflag;
        CMP_Flag   <= (ALU_FUN[3:2] == CLS_CMP);
        Shift_Flag <= (ALU_FUN[3:2] == CLS_SHIFT);
        case (ALU_FUN)
            OP_ADD:   begin Arith_OUT <= sum; Carry_OUT <= sum[W]; end
            OP_SUB:   Arith_OUT <= {{W{1'b0}}, ALU_A - ALU_B};
            OP_MUL:   Arith_OUT <= ALU_A * ALU_B;
            OP_DIV:   Arith_OUT <= (ALU_B == '0) ? 32'h0000_FFFF : {{W{1'b0}}, ALU_A / ALU_B};
            OP_AND:   Logic_OUT <= ALU_A & ALU_B;
            OP_OR:    Logic_OUT <= ALU_A | ALU_B;
            OP_NAND:  Logic_OUT <= ~(ALU_A & ALU_B);
            OP_NOR:   Logic_OUT <= ~(ALU_A | ALU_B);
            OP_EQ:    CMP_OUT <= (ALU_A == ALU_B) ? 3'd1 : 3'd0;
            OP_GT:    CMP_OUT <= (ALU_A > ALU_B) ? 3'd2 : 3'd0;
            OP_LT:    CMP_OUT <= (ALU_A < ALU_B) ? 3'd3 : 3'd0;
            OP_SHR_A: Shift_OUT <= ALU_A >> 1;
            OP_SHL_A: Shift_OUT <= ALU_A << 1;
            OP_SHR_B: Shift_OUT <= ALU_B >> 1;
            OP_SHL_B: Shift_OUT <= ALU_B << 1;
            default:  ;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a command, then step to the capture edge and check the response.
    task automatic run_op(input string tag, input logic [3:0] fun, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp_data,
                          input logic [1:0] exp_cls, input logic exp_err, input logic exp_carry);
        CMD_VALID = 1'b1;
        CMD_FUN   = fun;
        CMD_A     = a;
        CMD_B     = b;
        chk({tag, "_cmd_ready"}, 64'(CMD_READY), 64'd1);
        tick();
        CMD_VALID = 1'b0;
        chk({tag, "_alu_a"}, 64'(ALU_A), 64'(a));
        chk({tag, "_alu_fun"}, 64'(ALU_FUN), 64'(fun));
        chk({tag, "_state_wait"}, 64'(DBG_STATE), 64'(ST_WAIT));
        chk({tag, "_busy"}, 64'(CMD_READY), 64'd0);
        tick();
        chk({tag, "_valid_early"}, 64'(RSP_VALID), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(RSP_VALID), 64'd1);
        chk({tag, "_data"}, 64'(RSP_DATA), 64'(exp_data));
        chk({tag, "_class"}, 64'(RSP_CLASS), 64'(exp_cls));
        chk({tag, "_err"}, 64'(RSP_ERR), 64'(exp_err));
        chk({tag, "_carry"}, 64'(RSP_CARRY), 64'(exp_carry));
    endtask

    task automatic finish_op(input string tag, input logic [15:0] exp_cnt,
                             input logic [1:0] exp_cnt2);
        RSP_READY = 1'b1;
        tick();
        chk({tag, "_valid_drop"}, 64'(RSP_VALID), 64'd0);
        chk({tag, "_state_idle"}, 64'(DBG_STATE), 64'(ST_IDLE));
        chk({tag, "_op_cnt"}, 64'(OP_CNT), 64'(exp_cnt));
        chk({tag, "_op_cnt2"}, 64'(c2_op_cnt), 64'(exp_cnt2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cmd_ready", 64'(CMD_READY), 64'd1);
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        chk("rst_alu_a", 64'(ALU_A), 64'd0);
        chk("rst_alu_fun", 64'(ALU_FUN), 64'd0);
        chk("rst_op_cnt", 64'(OP_CNT), 64'd0);
        chk("rst_state", 64'(DBG_STATE), 64'(ST_IDLE));
        RST = 1'b1;
        RSP_READY = 1'b1;
        tick();

        run_op("add", OP_ADD, 16'd30, 16'd10, 32'd40, CLS_ARITH, 1'b0, 1'b0);
        finish_op("add", 16'd1, 2'd1);
        run_op("addc", OP_ADD, 16'hFFFF, 16'd1, 32'h0001_0000, CLS_ARITH, 1'b0, 1'b1);
        finish_op("addc", 16'd2, 2'd2);
        run_op("mul", OP_MUL, 16'd30, 16'd10, 32'd300, CLS_ARITH, 1'b0, 1'b0);
        finish_op("mul", 16'd3, 2'd3);
        run_op("and", OP_AND, 16'h00F0, 16'h0FF0, 32'h0000_00F0, CLS_LOGIC, 1'b0, 1'b0);
        finish_op("and", 16'd4, 2'd0);
        run_op("cmp_gt", OP_GT, 16'd30, 16'd10, 32'd2, CLS_CMP, 1'b0, 1'b0);
        finish_op("cmp_gt", 16'd5, 2'd1);
        run_op("shl_b", OP_SHL_B, 16'd30, 16'd10, 32'd20, CLS_SHIFT, 1'b0, 1'b0);
        finish_op("shl_b", 16'd6, 2'd2);
        run_op("div0", OP_DIV, 16'd30, 16'd0, 32'd0, CLS_ARITH, 1'b1, 1'b0);
        finish_op("div0", 16'd7, 2'd3);

        force_lflag = 1'b1;
        run_op("flag", OP_ADD, 16'd5, 16'd7, 32'd12, CLS_ARITH, 1'b1, 1'b0);
        force_lflag = 1'b0;
        finish_op("flag", 16'd8, 2'd0);

        // Response stall with a competing command that must be ignored.
        RSP_READY = 1'b0;
        run_op("stall", OP_SUB, 16'd30, 16'd10, 32'd20, CLS_ARITH, 1'b0, 1'b0);
        held_data = RSP_DATA;
        CMD_VALID = 1'b1;
        CMD_FUN   = OP_OR;
        CMD_A     = 16'h1234;
        CMD_B     = 16'h5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(RSP_VALID), 64'd1);
            chk("stall_data", 64'(RSP_DATA), 64'd20);
            chk("stall_cmd_ready", 64'(CMD_READY), 64'd0);
            chk("stall_alu_a", 64'(ALU_A), 64'd30);
        end
        chk("stall_held", 64'(held_data), 64'd20);
        CMD_VALID = 1'b0;
        finish_op("stall", 16'd9, 2'd1);
        chk("stall_no_accept", 64'(ALU_FUN), 64'(OP_SUB));

        // Reset while waiting on the ALU.
        CMD_VALID = 1'b1;
        CMD_FUN   = OP_ADD;
        CMD_A     = 16'd3;
        CMD_B     = 16'd4;
        tick();
        CMD_VALID = 1'b0;
        chk("mid_state_wait", 64'(DBG_STATE), 64'(ST_WAIT));
        RST = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(CMD_READY), 64'd1);
        chk("mid_rst_valid", 64'(RSP_VALID), 64'd0);
        chk("mid_rst_alu_a", 64'(ALU_A), 64'd0);
        chk("mid_rst_alu_b", 64'(ALU_B), 64'd0);
        chk("mid_rst_op_cnt", 64'(OP_CNT), 64'd0);
        chk("mid_rst_data", 64'(RSP_DATA), 64'd0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_valid", 64'(RSP_VALID), 64'd0);
        end

        // Four operations after reset: the 2-bit counter returns to 0.
        run_op("w1", OP_EQ, 16'd9, 16'd9, 32'd1, CLS_CMP, 1'b0, 1'b0);
        finish_op("w1", 16'd1, 2'd1);
        run_op("w2", OP_NOR, 16'h00FF, 16'h0F00, 32'h0000_F000, CLS_LOGIC, 1'b0, 1'b0);
        finish_op("w2", 16'd2, 2'd2);
        run_op("w3", OP_SHR_A, 16'h0080, 16'd0, 32'h0000_0040, CLS_SHIFT, 1'b0, 1'b0);
        finish_op("w3", 16'd3, 2'd3);
        run_op("w4", OP_DIV, 16'd30, 16'd5, 32'd6, CLS_ARITH, 1'b0, 1'b0);
        finish_op("w4", 16'd4, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
